sync_rx_pkt_fifo: RTL and testbench

//  Synchronous packet FIFO on the USB receive (OUT) path: USB RX engine writes packet bytes, I2S/consumer side reads.

---
 rtl/sync_rx_pkt_fifo.sv | 119 +++++++++++
 tb/tb_sync_rx_pkt_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sync_rx_pkt_fifo.sv
// Receive-path packet FIFO: bytes are written speculatively and exposed to
// the reader only on commit; dropped or overflowed packets are rewound.
module sync_rx_pkt_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 9
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             write,
  input  logic [DSIZE-1:0] iData,
  input  logic             pktend,
  input  logic             pktdrop,
  input  logic             read,
  output logic [DSIZE-1:0] oData,
  output logic             oValid,
  output logic [ASIZE:0]   rdnum,
  output logic             full,
  output logic             empty,
  output logic             pkt_ok,
  output logic             pkt_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;
  localparam logic [ASIZE:0] ONE = 1;

  logic [DSIZE-1:0] r_mem [2**ASIZE];
  logic [ASIZE:0]   r_wp;
  logic [ASIZE:0]   r_cwp;
  logic [ASIZE:0]   r_rp;
  logic [1:0]       r_state;
  logic [DSIZE-1:0] r_odata;
  logic             r_ovalid;
  logic [ASIZE:0]   r_rdnum;
  logic             r_pkt_ok;
  logic             r_pkt_err;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_commit;
  logic             w_drop;
  logic [ASIZE:0]   w_wp_nxt;
  logic [ASIZE:0]   w_cwp_nxt;
  logic [ASIZE:0]   w_rp_nxt;
  logic [1:0]       w_state_nxt;

  assign w_full  = (r_wp[ASIZE] ^ r_rp[ASIZE]) &
                   (r_wp[ASIZE-1:0] == r_rp[ASIZE-1:0]);
  assign w_empty = (r_rp == r_cwp);

  assign w_wr_acc = write & ~w_full & (r_state != S_DISC);
  assign w_rd_acc = read & ~w_empty;
  assign w_drop   = pktdrop | (pktend & (r_state == S_DISC));
  assign w_commit = pktend & ~pktdrop & (r_state != S_DISC);

  always_comb begin
    w_wp_nxt    = r_wp;
    w_cwp_nxt   = r_cwp;
    w_rp_nxt    = r_rp;
    w_state_nxt = r_state;
    if (w_drop)
      w_wp_nxt = r_cwp;
    else if (w_wr_acc)
      w_wp_nxt = r_wp + ONE;
    // commit includes a byte accepted in the same cycle
    if (w_commit)
      w_cwp_nxt = w_wp_nxt;
    if (w_rd_acc)
      w_rp_nxt = r_rp + ONE;
    if (pktend | pktdrop)
      w_state_nxt = S_IDLE;
    else if (r_state != S_DISC && write && w_full)
      w_state_nxt = S_DISC;
    else if (r_state == S_IDLE && w_wr_acc)
      w_state_nxt = S_RECV;
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_wr_acc)
      r_mem[r_wp[ASIZE-1:0]] <= iData;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wp      <= '0;
      r_cwp     <= '0;
      r_rp      <= '0;
      r_state   <= S_IDLE;
      r_odata   <= '0;
      r_ovalid  <= 1'b0;
      r_rdnum   <= '0;
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
    end else begin
      r_wp      <= w_wp_nxt;
      r_cwp     <= w_cwp_nxt;
      r_rp      <= w_rp_nxt;
      r_state   <= w_state_nxt;
      r_ovalid  <= w_rd_acc;
      if (w_rd_acc)
        r_odata <= r_mem[r_rp[ASIZE-1:0]];
      r_rdnum   <= w_cwp_nxt - w_rp_nxt;
      r_pkt_ok  <= w_commit;
      r_pkt_err <= w_drop;
    end
  end

  assign oData   = r_odata;
  assign oValid  = r_ovalid;
  assign rdnum   = r_rdnum;
  assign full    = w_full;
  assign empty   = w_empty;
  assign pkt_ok  = r_pkt_ok;
  assign pkt_err = r_pkt_err;

endmodule

// File: tb/tb_sync_rx_pkt_fifo.sv
// Directed bench for sync_rx_pkt_fifo at ASIZE=4 (depth 16).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_sync_rx_pkt_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             write;
  logic [DSIZE-1:0] iData;
  logic             pktend;
  logic             pktdrop;
  logic             read;
  logic [DSIZE-1:0] oData;
  logic             oValid;
  logic [ASIZE:0]   rdnum;
  logic             full;
  logic             empty;
  logic             pkt_ok;
  logic             pkt_err;

  int n_chk = 0;
  int n_err = 0;

  sync_rx_pkt_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .CLK(CLK), .RST(RST), .write(write), .iData(iData),
    .pktend(pktend), .pktdrop(pktdrop), .read(read),
    .oData(oData), .oValid(oValid), .rdnum(rdnum),
    .full(full), .empty(empty), .pkt_ok(pkt_ok), .pkt_err(pkt_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic w, input logic [7:0] d,
                     input logic pe, input logic pd, input logic r);
    RST = rst; write = w; iData = d; pktend = pe; pktdrop = pd; read = r;
    @(posedge CLK);
    #1;
    RST = 0; write = 0; iData = 0; pktend = 0; pktdrop = 0; read = 0;
  endtask

  task automatic do_reset();
    cyc(1, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic wr(input logic [7:0] d, input logic pe);
    cyc(0, 1, d, pe, 0, 0);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] d);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check({tag, "_v"}, oValid, 1);
    check({tag, "_d"}, oData, d);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end

  initial begin
    RST = 1; write = 0; iData = 0; pktend = 0; pktdrop = 0; read = 0;
    @(posedge CLK); #1;
    do_reset();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rdnum", rdnum, 0);
    check("rst_ovalid", oValid, 0);
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 0);
    check("t1_empty", empty, 1);
    check("t1_rdnum", rdnum, 0);

    do_reset();
    wr(8'hA0, 0); wr(8'hA1, 0); wr(8'hA2, 0); wr(8'hA3, 1);
    check("t2_ok", pkt_ok, 1);
    check("t2_err", pkt_err, 0);
    check("t2_rdnum", rdnum, 4);
    check("t2_empty", empty, 0);
    rd_chk("t2_r0", 8'hA0);
    check("t2_ok_pulse", pkt_ok, 0);
    rd_chk("t2_r1", 8'hA1);
    rd_chk("t2_r2", 8'hA2);
    rd_chk("t2_r3", 8'hA3);
    check("t2_empty_end", empty, 1);
    check("t2_rdnum_end", rdnum, 0);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("t2_ovalid_lo", oValid, 0);
    check("t2_odata_hold", oData, 8'hA3);

    do_reset();
    wr(8'hB0, 0); wr(8'hB1, 0); wr(8'hB2, 1);
    check("t3_ok", pkt_ok, 1);
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 0);
    check("t3_rdnum_spec", rdnum, 3);
    cyc(0, 0, 8'h00, 0, 1, 0);
    check("t3_err", pkt_err, 1);
    check("t3_ok0", pkt_ok, 0);
    check("t3_rdnum", rdnum, 3);
    rd_chk("t3_r0", 8'hB0);
    rd_chk("t3_r1", 8'hB1);
    rd_chk("t3_r2", 8'hB2);
    check("t3_empty", empty, 1);
    wr(8'hB7, 1);
    rd_chk("t3_after", 8'hB7);

    do_reset();
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 0);
    check("t4_full16", full, 1);
    check("t4_rdnum", rdnum, 0);
    wr(8'h50, 0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check("t4_err", pkt_err, 1);
    check("t4_ok0", pkt_ok, 0);
    check("t4_empty", empty, 1);
    check("t4_full0", full, 0);
    wr(8'hD0, 1);
    check("t4_ok_after", pkt_ok, 1);
    rd_chk("t4_r", 8'hD0);

    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 7; k++) wr(8'(p * 16 + k), k == 6);
      check("t5_rdnum7", rdnum, 7);
      check("t5_full", full, 0);
      for (int k = 0; k < 7; k++) rd_chk("t5_rd", 8'(p * 16 + k));
      check("t5_rdnum0", rdnum, 0);
      check("t5_empty", empty, 1);
    end

    do_reset();
    wr(8'hE0, 0);
    cyc(0, 1, 8'hE1, 1, 1, 0);
    check("t6_err", pkt_err, 1);
    check("t6_ok0", pkt_ok, 0);
    check("t6_empty", empty, 1);
    check("t6_rdnum", rdnum, 0);
    wr(8'hF0, 1);
    check("t6_ok", pkt_ok, 1);
    rd_chk("t6_r", 8'hF0);
    wr(8'h61, 0); wr(8'h62, 0); wr(8'h63, 1);
    wr(8'h64, 0); wr(8'h65, 0);
    check("t6_rdnum_pre", rdnum, 3);
    cyc(1, 1, 8'h66, 0, 0, 1);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_full", full, 0);
    check("t6_rst_rdnum", rdnum, 0);
    check("t6_rst_ovalid", oValid, 0);
    check("t6_rst_odata", oData, 0);
    check("t6_rst_ok", pkt_ok, 0);
    check("t6_rst_err", pkt_err, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
